// File: rtl/rtc_bus_pkg.sv
// Shared encodings for the RTC bus sequencer: FSM states, transfer direction, phase defaults.
package rtc_bus_pkg;

    localparam int unsigned T_PHASE_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned TMR_W       = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_HOLD = 3'd2,
        DATA      = 3'd3,
        RECOVER   = 3'd4
    } state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: loadable down-counter; terminal count is flagged when the count reaches zero.
module rtc_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc_c
);

    logic [W-1:0] r_count;

    // Reload on state entry, otherwise count down and stop at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: arbitrates write/read requesters and runs one timed
// address/data bus cycle per grant. Strobes are registered from the current state,
// so the pins follow the FSM by one cycle.
// Optional macro RTC_ARB_ROUND_ROBIN_EN: round-robin arbitration when both requests
// are pending; when undefined, write has fixed priority.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PHASE = T_PHASE_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [ADDR_W-1:0] bus_in,
    output logic              CS,
    output logic              AD,
    output logic              RD,
    output logic              WR,
    output logic              busy
);

    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(T_PHASE - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    dir_e              r_dir;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_data;
    logic              w_tc;
    logic              w_load;
    logic              w_grant_any;
    logic              w_grant_wr;
    logic              w_cs;
    logic              w_ad;
    logic              w_rd;
    logic              w_wr;
    logic              w_oe;
    logic [ADDR_W-1:0] w_bus_out;
    logic              w_ack_nxt;
    logic              w_valid_nxt;

`ifdef RTC_ARB_ROUND_ROBIN_EN
    logic r_rr_wr;

    // Round-robin pointer: side preferred at the next contested grant.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_rr_wr <= 1'b1;
        end else if (r_state == IDLE && w_grant_any) begin
            r_rr_wr <= ~w_grant_wr;
        end
    end

    // Arbitration: single request wins, contention goes to the preferred side.
    always_comb begin
        w_grant_any = wr_req | rd_req;
        w_grant_wr  = wr_req & (~rd_req | r_rr_wr);
    end
`else
    // Arbitration: fixed priority, write wins.
    always_comb begin
        w_grant_any = wr_req | rd_req;
        w_grant_wr  = wr_req;
    end
`endif

    // Phase timer reloaded on every state change.
    assign w_load = (w_state_nxt != r_state);

    rtc_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (CLK),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .o_tc_c     (w_tc)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE waits for a request, other states last one phase.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_grant_any) w_state_nxt = ADDR;
            ADDR:      if (w_tc)        w_state_nxt = ADDR_HOLD;
            ADDR_HOLD: if (w_tc)        w_state_nxt = DATA;
            DATA:      if (w_tc)        w_state_nxt = RECOVER;
            RECOVER:   if (w_tc)        w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Latch the granted transfer so later input changes cannot disturb it.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_dir  <= DIR_RD;
            r_addr <= '0;
            r_data <= '0;
        end else if (r_state == IDLE && w_grant_any) begin
            r_dir  <= w_grant_wr ? DIR_WR : DIR_RD;
            r_addr <= w_grant_wr ? wr_addr : rd_addr;
            r_data <= wr_data;
        end
    end

    // Output decode from the current state.
    always_comb begin
        w_cs        = 1'b1;
        w_ad        = 1'b1;
        w_rd        = 1'b1;
        w_wr        = 1'b1;
        w_oe        = 1'b0;
        w_bus_out   = bus_out;
        w_ack_nxt   = (r_state == DATA) && w_tc && (r_dir == DIR_WR);
        w_valid_nxt = (r_state == DATA) && w_tc && (r_dir == DIR_RD);
        case (r_state)
            ADDR: begin
                w_cs      = 1'b0;
                w_ad      = 1'b0;
                w_oe      = 1'b1;
                w_bus_out = r_addr;
            end
            ADDR_HOLD: begin
                w_cs      = 1'b0;
                w_oe      = 1'b1;
                w_bus_out = r_addr;
            end
            DATA: begin
                w_cs = 1'b0;
                if (r_dir == DIR_WR) begin
                    w_wr      = 1'b0;
                    w_oe      = 1'b1;
                    w_bus_out = r_data;
                end else begin
                    w_rd = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers; read data is captured while RD is still low.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            CS       <= 1'b1;
            AD       <= 1'b1;
            RD       <= 1'b1;
            WR       <= 1'b1;
            bus_oe   <= 1'b0;
            bus_out  <= '0;
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            busy     <= 1'b0;
        end else begin
            CS       <= w_cs;
            AD       <= w_ad;
            RD       <= w_rd;
            WR       <= w_wr;
            bus_oe   <= w_oe;
            bus_out  <= w_bus_out;
            wr_ack   <= w_ack_nxt;
            rd_valid <= w_valid_nxt;
            busy     <= (w_state_nxt != IDLE);
            if (w_valid_nxt) begin
                rd_data <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer (T_PHASE=4). A transaction-level model
// tracks cycles elapsed since each grant and derives the expected pins from it.
module tb_rtc_bus_sequencer;

    localparam int TP  = 4;
    localparam int BIG = 100000;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    logic       CS, AD, RD, WR;
    logic       busy;
    logic [7:0] rd_resp = 8'h00;

    int n_vec = 0;
    int n_err = 0;

    // RTC device: presents its register value only while RD is asserted.
    assign bus_in = (RD == 1'b0) ? rd_resp : 8'hEE;

    rtc_bus_sequencer #(.T_PHASE(TP), .ADDR_W(8)) dut (
        .CLK(CLK), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .CS(CS), .AD(AD), .RD(RD), .WR(WR), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         m_el = BIG;   // cycles since last grant edge (1 = cycle right after it)
    bit         m_wr = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rd_data = 8'h00;
    bit         m_pref_wr = 1'b1;
    bit         m_fresh = 1'b1;
    bit         m_log[$];

    always @(posedge CLK) begin
        if (!reset) begin
            m_el      = BIG;
            m_pref_wr = 1'b1;
            m_rd_data = 8'h00;
            m_fresh   = 1'b1;
        end else begin
            if (m_el >= 4*TP+1 && (wr_req || rd_req)) begin
                if (wr_req && !rd_req)      m_wr = 1'b1;
                else if (rd_req && !wr_req) m_wr = 1'b0;
`ifdef RTC_ARB_ROUND_ROBIN_EN
                else                        m_wr = m_pref_wr;
                m_pref_wr = !m_wr;
`else
                else                        m_wr = 1'b1;
`endif
                m_addr  = m_wr ? wr_addr : rd_addr;
                m_data  = wr_data;
                m_el    = 1;
                m_fresh = 1'b0;
                m_log.push_back(m_wr);
            end else if (m_el < BIG) begin
                m_el++;
            end
            if (m_el == 3*TP+1 && !m_wr) m_rd_data = rd_resp;
        end
    end

    // Expected {CS,AD,RD,WR,oe,ack,valid,busy} as a function of elapsed cycles.
    function automatic logic [7:0] exp_pins(input int el, input bit wr);
        logic cs, ad, rd, wn, oe, ack, vld, bsy;
        cs = 1'b1; ad = 1'b1; rd = 1'b1; wn = 1'b1; oe = 1'b0;
        if (el >= 2 && el <= TP+1) begin
            cs = 1'b0; ad = 1'b0; oe = 1'b1;
        end else if (el >= TP+2 && el <= 2*TP+1) begin
            cs = 1'b0; oe = 1'b1;
        end else if (el >= 2*TP+2 && el <= 3*TP+1) begin
            cs = 1'b0;
            if (wr) begin wn = 1'b0; oe = 1'b1; end
            else    rd = 1'b0;
        end
        ack = wr && (el == 3*TP+1);
        vld = !wr && (el == 3*TP+1);
        bsy = (el >= 1) && (el <= 4*TP);
        return {cs, ad, rd, wn, oe, ack, vld, bsy};
    endfunction

    // Compare process: every cycle, away from the active edge.
    always @(negedge CLK) begin
        logic [7:0] e;
        e = exp_pins(m_el, m_wr);
        check("pins{CS,AD,RD,WR,oe,ack,valid,busy}",
              32'({CS, AD, RD, WR, bus_oe, wr_ack, rd_valid, busy}), 32'(e));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
        if (e[3]) check("bus_out", 32'(bus_out), 32'((m_el <= 2*TP+1) ? m_addr : m_data));
        if (m_fresh) check("bus_out_reset", 32'(bus_out), 32'h0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(output int cyc, output bit got_wr, output int n_addr,
                             output int n_wlow, output int n_rlow,
                             output logic [7:0] last_addr, output logic [7:0] last_wdat);
        bit done;
        done = 0; cyc = 0; got_wr = 0; n_addr = 0; n_wlow = 0; n_rlow = 0;
        last_addr = 8'h00; last_wdat = 8'h00;
        while (!done && cyc < 200) begin
            @(posedge CLK); #1; cyc++;
            if (!CS && !AD && bus_oe) n_addr++;
            if (!CS && bus_oe && WR) last_addr = bus_out;
            if (!WR && bus_oe) begin n_wlow++; last_wdat = bus_out; end
            if (!RD && !bus_oe) n_rlow++;
            if (wr_ack || rd_valid) begin done = 1; got_wr = wr_ack; end
        end
        if (!done) check("done_timeout", 32'(done), 32'h1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin @(posedge CLK); #1; n++; end
        if (busy) check("idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, na, nw, nr, n;
        bit gw;
        logic [7:0] la, lw;
        logic [3:0] ord, mord;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_strobes", 32'({CS, AD, RD, WR}), 32'hF);
        check("rst_oe_busy", 32'({bus_oe, busy, wr_ack, rd_valid}), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge CLK);

        // Single write
        #1; wr_addr = 8'h02; wr_data = 8'h35; wr_req = 1'b1;
        wait_done(cyc, gw, na, nw, nr, la, lw);
        wr_req = 1'b0;
        check("wr_ack_latency", 32'(cyc), 32'd13);
        check("wr_dir", 32'(gw), 32'h1);
        check("wr_addr_cycles", 32'(na), 32'd4);
        check("wr_addr_value", 32'(la), 32'h02);
        check("wr_low_cycles", 32'(nw), 32'd4);
        check("wr_data_value", 32'(lw), 32'h35);
        check("wr_no_rd", 32'(nr), 32'd0);
        wait_idle(n);
        check("wr_busy_fall", 32'(n), 32'd4);

        // Single read
        @(posedge CLK); #1;
        rd_addr = 8'h04; rd_resp = 8'h17; rd_req = 1'b1;
        wait_done(cyc, gw, na, nw, nr, la, lw);
        rd_req = 1'b0;
        check("rd_valid_latency", 32'(cyc), 32'd13);
        check("rd_dir", 32'(gw), 32'h0);
        check("rd_low_cycles", 32'(nr), 32'd4);
        check("rd_addr_value", 32'(la), 32'h04);
        check("rd_data_value", 32'(rd_data), 32'h17);
        check("rd_no_wr", 32'(nw), 32'd0);
        wait_idle(n);

        // Both requests held for four transactions
        @(posedge CLK); #1;
        m_log.delete();
        wr_addr = 8'h10; wr_data = 8'h20; rd_addr = 8'h30; rd_resp = 8'h44;
        wr_req = 1'b1; rd_req = 1'b1;
        ord = 4'h0;
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc, gw, na, nw, nr, la, lw);
            ord = {ord[2:0], gw};
        end
        wr_req = 1'b0; rd_req = 1'b0;
        mord = 4'h0;
        for (int i = 0; i < 4 && i < m_log.size(); i++) mord = {mord[2:0], m_log[i]};
`ifdef RTC_ARB_ROUND_ROBIN_EN
        check("arb_order_dut", 32'(ord), 32'hA);
        check("arb_order_model", 32'(mord), 32'hA);
`else
        check("arb_order_dut", 32'(ord), 32'hF);
        check("arb_order_model", 32'(mord), 32'hF);
`endif
        wait_idle(n);

        // Reset during DATA of a write
        @(posedge CLK); #1;
        wr_addr = 8'h05; wr_data = 8'h66; wr_req = 1'b1;
        n = 0;
        while (WR && n < 100) begin @(posedge CLK); #1; n++; end
        check("saw_wr_low", 32'(WR), 32'h0);
        reset = 1'b0;
        @(posedge CLK); #1;
        check("mid_rst_strobes", 32'({CS, AD, RD, WR}), 32'hF);
        check("mid_rst_oe_ack_busy", 32'({bus_oe, wr_ack, busy}), 32'h0);
        check("mid_rst_rd_data", 32'(rd_data), 32'h0);
        wr_req = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (wr_ack || busy) n++;
        end
        check("no_ack_after_reset", 32'(n), 32'd0);

        // Address/data changed during ADDR_HOLD
        wr_addr = 8'h0A; wr_data = 8'h5C; wr_req = 1'b1;
        n = 0;
        while (!(!CS && AD && bus_oe) && n < 100) begin @(posedge CLK); #1; n++; end
        wr_addr = 8'h99; wr_data = 8'h11;
        wait_done(cyc, gw, na, nw, nr, la, lw);
        wr_req = 1'b0;
        check("hold_addr_kept", 32'(la), 32'h0A);
        check("hold_data_kept", 32'(lw), 32'h5C);
        wait_idle(n);

        // Read request dropped before grant while a write is running
        @(posedge CLK); #1;
        wr_addr = 8'h21; wr_data = 8'h42; wr_req = 1'b1;
        repeat (3) @(posedge CLK);
        #1; rd_addr = 8'h07; rd_req = 1'b1;
        repeat (5) @(posedge CLK);
        #1; rd_req = 1'b0;
        wait_done(cyc, gw, na, nw, nr, la, lw);
        wr_req = 1'b0;
        check("drop_served_write", 32'(gw), 32'h1);
        wait_idle(n);
        check("drop_busy_fall", 32'(n), 32'd4);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK); #1;
            if (!RD || rd_valid || busy) n++;
        end
        check("drop_no_read", 32'(n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
